// File: rtl/hack_pkg.sv
// Shared definitions for the Hack data-RAM arbiter: word size, owner
// encoding and the arbiter state encoding.
package hack_pkg;

  // Hack machine word width.
  localparam int N = 16;

  // Owner encoding used for last-grant tracking and read-return steering.
  localparam logic OWN_CPU  = 1'b0;
  localparam logic OWN_HOST = 1'b1;

  // Arbiter state encoding (who owned the RAM in the previous cycle).
  localparam logic [1:0] ENC_IDLE  = 2'd0;
  localparam logic [1:0] ENC_CPU   = 2'd1;
  localparam logic [1:0] ENC_HOST  = 2'd2;
  localparam logic [1:0] ENC_HLOCK = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = ENC_IDLE,
    ST_CPU   = ENC_CPU,
    ST_HOST  = ENC_HOST,
    ST_HLOCK = ENC_HLOCK
  } arb_state_e;

  // Wait counters only need to reach MAX_WAIT, which is at most 15.
  localparam int WAIT_W = 4;

endpackage

// File: rtl/hack_ram_arbiter_sat_wait_counter.sv
// Saturating count of consecutive denied cycles for one requester.
module sat_wait_counter #(
  parameter int WIDTH = 4,
  parameter int MAX   = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic at_max
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Next count: clear wins, otherwise step up until the ceiling.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != MAX_V)) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  // Count register, cleared by the asynchronous reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign at_max = (count_q == MAX_V);

endmodule

// File: rtl/hack_ram_arbiter.sv
// Arbiter sharing the single-port Hack data RAM between the CPU data port
// and a host port. One access per cycle; the losing CPU is stalled.
//
// state    | meaning
// ---------+------------------------------------------------
// ST_IDLE  | nobody owned the RAM last cycle
// ST_CPU   | CPU won last cycle
// ST_HOST  | host won last cycle without lock
// ST_HLOCK | host won last cycle holding host_lock (burst)
module hack_ram_arbiter
  import hack_pkg::*;
#(
  parameter int AW       = 16,
  parameter int DW       = N,
  parameter int MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_stall,
  output logic          cpu_rvalid,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  input  logic          host_lock,
  output logic          host_gnt,
  output logic          host_rvalid,
  output logic [DW-1:0] rdata,
  output logic          ram_en,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata
);

  arb_state_e state_q;
  logic       last_gnt_q;
  logic       rd_valid_q;
  logic       rd_owner_q;

  logic       cpu_win;
  logic       host_win;
  logic       cpu_at_max;
  logic       host_at_max;

  // Winner selection. While reset is asserted nobody is granted, so the CPU
  // sees a stall for as long as it requests.
  always_comb begin
    cpu_win  = 1'b0;
    host_win = 1'b0;
    if (rst) begin
      if (cpu_req && !host_req) begin
        cpu_win = 1'b1;
      end else if (host_req && !cpu_req) begin
        host_win = 1'b1;
      end else if (cpu_req && host_req) begin
        // Starvation limits override the lock; the CPU limit is checked
        // first so a locked burst can never shut the CPU out indefinitely.
        if (cpu_at_max) begin
          cpu_win = 1'b1;
        end else if (host_at_max) begin
          host_win = 1'b1;
        end else if (state_q == ST_HLOCK) begin
          host_win = 1'b1;
        end else if (last_gnt_q == OWN_HOST) begin
          cpu_win = 1'b1;
        end else begin
          host_win = 1'b1;
        end
      end
    end
  end

  // Per-side starvation counters: count denied cycles, reset on grant or
  // when the side stops asking.
  sat_wait_counter #(
    .WIDTH (WAIT_W),
    .MAX   (MAX_WAIT)
  ) u_cpu_wait (
    .clk    (clk),
    .rst    (rst),
    .inc    (cpu_req & ~cpu_win),
    .clr    (~cpu_req | cpu_win),
    .at_max (cpu_at_max)
  );

  sat_wait_counter #(
    .WIDTH (WAIT_W),
    .MAX   (MAX_WAIT)
  ) u_host_wait (
    .clk    (clk),
    .rst    (rst),
    .inc    (host_req & ~host_win),
    .clr    (~host_req | host_win),
    .at_max (host_at_max)
  );

  // Ownership FSM, last-grant memory and read-return tracking. Reset clears
  // rd_valid_q asynchronously, so a read in flight at reset never returns.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      last_gnt_q <= OWN_HOST;
      rd_valid_q <= 1'b0;
      rd_owner_q <= OWN_CPU;
    end else begin
      if (cpu_win) begin
        state_q    <= ST_CPU;
        last_gnt_q <= OWN_CPU;
      end else if (host_win) begin
        state_q    <= host_lock ? ST_HLOCK : ST_HOST;
        last_gnt_q <= OWN_HOST;
      end else begin
        state_q    <= ST_IDLE;
      end
      rd_valid_q <= (cpu_win & ~cpu_we) | (host_win & ~host_we);
      rd_owner_q <= host_win ? OWN_HOST : OWN_CPU;
    end
  end

  // RAM port mux: the winner drives the macro, otherwise everything is zero.
  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (cpu_win) begin
      ram_en    = 1'b1;
      ram_we    = cpu_we;
      ram_addr  = cpu_addr;
      ram_wdata = cpu_wdata;
    end else if (host_win) begin
      ram_en    = 1'b1;
      ram_we    = host_we;
      ram_addr  = host_addr;
      ram_wdata = host_wdata;
    end
  end

  assign cpu_stall   = cpu_req & ~cpu_win;
  assign host_gnt    = host_win;
  assign cpu_rvalid  = rd_valid_q & (rd_owner_q == OWN_CPU);
  assign host_rvalid = rd_valid_q & (rd_owner_q == OWN_HOST);
  assign rdata       = (cpu_rvalid | host_rvalid) ? ram_rdata : '0;

endmodule

// File: tb/tb_hack_ram_arbiter.sv
// Directed bench for hack_ram_arbiter with a behavioural 1-cycle RAM.
module tb_hack_ram_arbiter;

  localparam int AW = 16;
  localparam int DW = 16;

  logic          clk;
  logic          rst;
  logic          cpu_req, cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_stall, cpu_rvalid;
  logic          host_req, host_we, host_lock;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata;
  logic          host_gnt, host_rvalid;
  logic [DW-1:0] rdata;
  logic          ram_en, ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;

  logic [DW-1:0] mem [0:65535];

  int vectors;
  int miscompares;

  hack_ram_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .cpu_req     (cpu_req),
    .cpu_we      (cpu_we),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_stall   (cpu_stall),
    .cpu_rvalid  (cpu_rvalid),
    .host_req    (host_req),
    .host_we     (host_we),
    .host_addr   (host_addr),
    .host_wdata  (host_wdata),
    .host_lock   (host_lock),
    .host_gnt    (host_gnt),
    .host_rvalid (host_rvalid),
    .rdata       (rdata),
    .ram_en      (ram_en),
    .ram_we      (ram_we),
    .ram_addr    (ram_addr),
    .ram_wdata   (ram_wdata),
    .ram_rdata   (ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM macro model: synchronous write, 1-cycle read latency.
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata <= mem[ram_addr];
    end
  end

  task automatic drive(input logic creq, input logic cwe, input logic [AW-1:0] caddr,
                       input logic [DW-1:0] cwd, input logic hreq, input logic hwe,
                       input logic [AW-1:0] haddr, input logic [DW-1:0] hwd,
                       input logic hlock);
    cpu_req = creq; cpu_we = cwe; cpu_addr = caddr; cpu_wdata = cwd;
    host_req = hreq; host_we = hwe; host_addr = haddr; host_wdata = hwd;
    host_lock = hlock;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    drive(1'b1, 1'b1, 16'h0001, 16'h0001, 1'b1, 1'b1, 16'h0002, 16'h0002, 1'b0);
    @(negedge clk); #1;
    vectors++;
    if ({cpu_stall, host_gnt, ram_en, ram_we} !== 4'b1000) begin
      miscompares++;
      $display("FAIL reset_grants: got %b expected %b", {cpu_stall, host_gnt, ram_en, ram_we}, 4'b1000);
    end
    vectors++;
    if ({cpu_rvalid, host_rvalid, ram_addr} !== {2'b00, 16'h0000}) begin
      miscompares++;
      $display("FAIL reset_rvalid_addr: got %b/%h expected 00/0000", {cpu_rvalid, host_rvalid}, ram_addr);
    end
    @(negedge clk);
    rst = 1'b1;
    drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
  endtask

  task automatic test_round_robin;
    logic e;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(1'b1, 1'b1, 16'h0020 + 16'(i), 16'hA000 + 16'(i),
            1'b1, 1'b1, 16'h0040 + 16'(i), 16'hB000 + 16'(i), 1'b0);
      #1;
      e = (i % 2) == 1;
      vectors++;
      if ({cpu_stall, host_gnt, ram_en} !== {e, e, 1'b1}) begin
        miscompares++;
        $display("FAIL rr_grant cycle %0d: got %b expected %b", i, {cpu_stall, host_gnt, ram_en}, {e, e, 1'b1});
      end
      vectors++;
      if (ram_addr !== (e ? 16'h0040 + 16'(i) : 16'h0020 + 16'(i))) begin
        miscompares++;
        $display("FAIL rr_addr cycle %0d: got %h", i, ram_addr);
      end
    end
    @(negedge clk);
    drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
  endtask

  task automatic test_cpu_only;
    @(negedge clk);
    drive(1'b1, 1'b1, 16'h0010, 16'h1234, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    #1;
    vectors++;
    if ({ram_en, ram_we, cpu_stall, host_gnt, ram_addr, ram_wdata} !== {4'b1100, 16'h0010, 16'h1234}) begin
      miscompares++;
      $display("FAIL cpu_write: got %b %h %h", {ram_en, ram_we, cpu_stall, host_gnt}, ram_addr, ram_wdata);
    end
    @(negedge clk);
    drive(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    #1;
    vectors++;
    if ({ram_en, ram_we, cpu_stall, cpu_rvalid, host_rvalid} !== 5'b10000) begin
      miscompares++;
      $display("FAIL cpu_read_issue: got %b expected 10000", {ram_en, ram_we, cpu_stall, cpu_rvalid, host_rvalid});
    end
    @(negedge clk);
    drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    #1;
    vectors++;
    if ({cpu_rvalid, host_rvalid, ram_en, rdata} !== {3'b100, 16'h1234}) begin
      miscompares++;
      $display("FAIL cpu_read_return: got %b rdata %h expected 100 rdata 1234", {cpu_rvalid, host_rvalid, ram_en}, rdata);
    end
  endtask

  // Last grant went to the CPU, so the host takes the first tie, holds it
  // with lock, and the CPU is forced in once it has waited 4 cycles.
  task automatic test_lock_starvation;
    logic [8:0] exp_h;
    logic e;
    exp_h = 9'b111101111;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      drive(1'b1, 1'b1, 16'h0100 + 16'(i), 16'hC000, 1'b1, 1'b1, 16'h0200 + 16'(i), 16'hD000, 1'b1);
      #1;
      e = exp_h[i];
      vectors++;
      if ({cpu_stall, host_gnt, ram_en} !== {e, e, 1'b1}) begin
        miscompares++;
        $display("FAIL lock_grant cycle %0d: got %b expected %b", i, {cpu_stall, host_gnt, ram_en}, {e, e, 1'b1});
      end
      vectors++;
      if (ram_wdata !== (e ? 16'hD000 : 16'hC000)) begin
        miscompares++;
        $display("FAIL lock_wdata cycle %0d: got %h", i, ram_wdata);
      end
    end
  endtask

  task automatic test_host_cancel;
    @(negedge clk);
    drive(1'b1, 1'b1, 16'h0300, 16'h0, 1'b1, 1'b1, 16'h0400, 16'h0, 1'b1);
    #1;
    vectors++;
    if ({cpu_stall, host_gnt, ram_en, ram_addr} !== {3'b001, 16'h0300}) begin
      miscompares++;
      $display("FAIL cancel_forced: got %b %h expected 001 0300", {cpu_stall, host_gnt, ram_en}, ram_addr);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(1'b1, 1'b1, 16'h0301 + 16'(i), 16'h0, 1'b0, 1'b1, 16'h0400, 16'h0, 1'b0);
      #1;
      vectors++;
      if ({cpu_stall, host_gnt, ram_en, ram_addr} !== {3'b001, 16'h0301 + 16'(i)}) begin
        miscompares++;
        $display("FAIL cancel_cpu cycle %0d: got %b %h", i, {cpu_stall, host_gnt, ram_en}, ram_addr);
      end
    end
  endtask

  task automatic test_idle_tie;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
      #1;
      vectors++;
      if ({ram_en, ram_we, host_gnt, cpu_stall, ram_addr} !== {4'b0000, 16'h0000}) begin
        miscompares++;
        $display("FAIL idle cycle %0d: got %b %h expected 0000 0000", i, {ram_en, ram_we, host_gnt, cpu_stall}, ram_addr);
      end
    end
    @(negedge clk);
    drive(1'b1, 1'b1, 16'h0500, 16'h0, 1'b1, 1'b1, 16'h0600, 16'h0, 1'b0);
    #1;
    vectors++;
    if ({cpu_stall, host_gnt} !== 2'b11) begin
      miscompares++;
      $display("FAIL idle_tie_first: got %b expected 11", {cpu_stall, host_gnt});
    end
    @(negedge clk);
    #1;
    vectors++;
    if ({cpu_stall, host_gnt} !== 2'b00) begin
      miscompares++;
      $display("FAIL idle_tie_second: got %b expected 00", {cpu_stall, host_gnt});
    end
  endtask

  task automatic test_reset_mid_read;
    @(negedge clk);
    drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 16'h7FFF, 16'h0, 1'b0);
    #1;
    vectors++;
    if ({host_gnt, ram_en, ram_we, ram_addr} !== {3'b110, 16'h7FFF}) begin
      miscompares++;
      $display("FAIL rst_read_issue: got %b %h expected 110 7fff", {host_gnt, ram_en, ram_we}, ram_addr);
    end
    @(posedge clk);
    rst = 1'b0;
    cpu_req = 1'b1;
    @(negedge clk); #1;
    vectors++;
    if ({host_rvalid, cpu_rvalid, ram_en, host_gnt, cpu_stall, rdata} !== {5'b00001, 16'h0000}) begin
      miscompares++;
      $display("FAIL rst_during: got %b rdata %h expected 00001 0000", {host_rvalid, cpu_rvalid, ram_en, host_gnt, cpu_stall}, rdata);
    end
    @(negedge clk);
    rst = 1'b1;
    drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    #1;
    vectors++;
    if ({host_rvalid, cpu_rvalid, ram_en} !== 3'b000) begin
      miscompares++;
      $display("FAIL rst_release: got %b expected 000", {host_rvalid, cpu_rvalid, ram_en});
    end
    @(negedge clk);
    drive(1'b1, 1'b1, 16'h0700, 16'h0, 1'b1, 1'b1, 16'h0800, 16'h0, 1'b0);
    #1;
    vectors++;
    if ({cpu_stall, host_gnt, host_rvalid} !== 3'b000) begin
      miscompares++;
      $display("FAIL rst_after_tie: got %b expected 000", {cpu_stall, host_gnt, host_rvalid});
    end
    @(negedge clk);
    drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_round_robin();
    test_cpu_only();
    test_lock_starvation();
    test_host_cancel();
    test_idle_tie();
    test_reset_mid_read();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
